// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that time-shares the car sprite ROM between renderers.
// It fetches one row per three cycles, only inside the horizontal-blank window.
module sprite_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIN_START = 256,
    parameter int WIN_END   = 300
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           hpos,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_addr,
    output logic [3:0]           rom_addr,
    input  logic [7:0]           rom_bits,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   data_valid,
    output logic [7:0]           load_bits,
    output logic                 busy,
    output logic                 overrun
);

    localparam int               IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0]       WIN_START_C = 9'(WIN_START);
    localparam logic [8:0]       WIN_END_C   = 9'(WIN_END);
    localparam logic [IDX_W-1:0] LAST_RST    = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [3:0]         rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] data_valid_q, data_valid_d;
    logic [7:0]         load_bits_q, load_bits_d;
    logic               overrun_q, overrun_d;
    logic               win_open_s;
    logic               start_s;
    logic [IDX_W-1:0]   winner_s;
    logic [IDX_W-1:0]   idx_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1'b1) << idx;
    endfunction

    assign win_open_s = (hpos >= WIN_START_C) && (hpos < WIN_END_C);

    // Winner search: scanning from farthest to nearest lets the nearest set bit after last win.
    always_comb begin
        winner_s = last_q;
        idx_s    = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s    = IDX_W'((int'(last_q) + k) % NUM_REQ);
            winner_s = req[idx_s] ? idx_s : winner_s;
        end
        start_s = win_open_s && (|req);
    end

    // State and datapath registers; reset aborts any fetch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            last_q       <= LAST_RST;
            rom_addr_q   <= 4'd0;
            grant_q      <= '0;
            data_valid_q <= '0;
            load_bits_q  <= 8'd0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            rom_addr_q   <= rom_addr_d;
            grant_q      <= grant_d;
            data_valid_q <= data_valid_d;
            load_bits_q  <= load_bits_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic: IDLE -> ADDR -> DONE -> IDLE, leaving IDLE only inside the window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = start_s ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; the address is captured at the grant decision.
    always_comb begin
        sel_d        = sel_q;
        last_d       = last_q;
        rom_addr_d   = rom_addr_q;
        load_bits_d  = load_bits_q;
        grant_d      = '0;
        data_valid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    sel_d      = winner_s;
                    last_d     = winner_s;
                    rom_addr_d = req_addr[{winner_s, 2'b00} +: 4];
                    grant_d    = onehot(winner_s);
                end else begin
                    grant_d    = '0;
                end
            end
            ST_ADDR: begin
                load_bits_d  = rom_bits;
                data_valid_d = onehot(sel_q);
            end
            ST_DONE: begin
                data_valid_d = '0;
            end
            default: begin
                grant_d      = '0;
                data_valid_d = '0;
            end
        endcase
        overrun_d = (hpos == WIN_END_C) && (|req);
    end

    assign rom_addr   = rom_addr_q;
    assign grant      = grant_q;
    assign data_valid = data_valid_q;
    assign load_bits  = load_bits_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: default window plus a short-window instance.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos;
    logic [3:0]  req, req2;
    logic [15:0] req_addr, req_addr2;
    logic [3:0]  rom_addr, rom_addr2;
    logic [7:0]  rom_bits, rom_bits2;
    logic [3:0]  grant, grant2, data_valid, data_valid2;
    logic [7:0]  load_bits, load_bits2;
    logic        busy, busy2, overrun, overrun2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_row(input logic [3:0] a);
        case (a)
            4'd0:  return 8'h0C;
            4'd1:  return 8'hCC;
            4'd2:  return 8'hEC;
            4'd3:  return 8'b11111100;
            4'd4:  return 8'hE0;
            4'd5:  return 8'h60;
            4'd6:  return 8'h70;
            4'd7:  return 8'h30;
            4'd8:  return 8'h31;
            4'd9:  return 8'h32;
            4'd10: return 8'h6E;
            4'd11: return 8'hEE;
            4'd12: return 8'hFE;
            4'd13: return 8'hEF;
            4'd14: return 8'h2E;
            default: return 8'h0E;
        endcase
    endfunction

    assign rom_bits  = rom_row(rom_addr);
    assign rom_bits2 = rom_row(rom_addr2);

    sprite_rom_arbiter #(.NUM_REQ(4), .WIN_START(256), .WIN_END(300)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .req(req), .req_addr(req_addr),
        .rom_addr(rom_addr), .rom_bits(rom_bits), .grant(grant),
        .data_valid(data_valid), .load_bits(load_bits), .busy(busy), .overrun(overrun)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .WIN_START(256), .WIN_END(262)) dut2 (
        .clk(clk), .reset(reset), .hpos(hpos), .req(req2), .req_addr(req_addr2),
        .rom_addr(rom_addr2), .rom_bits(rom_bits2), .grant(grant2),
        .data_valid(data_valid2), .load_bits(load_bits2), .busy(busy2), .overrun(overrun2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel clock; the new hpos names the cycle that has just begun.
    task automatic step();
        @(posedge clk);
        #1;
        hpos = (hpos == 9'd319) ? 9'd0 : hpos + 9'd1;
    endtask

    task automatic goto_h(input int target);
        int n;
        n = 0;
        while ((hpos != 9'(target)) && (n < 400)) begin
            step();
            n++;
        end
        check("goto_hpos", 32'(hpos), 32'(target));
    endtask

    initial begin
        reset = 1'b1;
        hpos = 9'd0;
        req = 4'd0;
        req2 = 4'd0;
        req_addr = 16'd0;
        req_addr2 = 16'd0;
        step();
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_load_bits", 32'(load_bits), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_grant2", 32'(grant2), 32'd0);
        reset = 1'b0;

        // Four simultaneous requests, served 0..3 back to back
        goto_h(100);
        req = 4'b1111;
        req_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        goto_h(256);
        check("t2_no_early_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_grant", 32'(grant), 32'(4'b0001 << i));
            check("t2_rom_addr", 32'(rom_addr), 32'(i + 1));
            step();
            check("t2_dv", 32'(data_valid), 32'(4'b0001 << i));
            check("t2_load_bits", 32'(load_bits), 32'(rom_row(4'(i + 1))));
            req[i] = 1'b0;
            step();
            check("t2_idle_busy", 32'(busy), 32'd0);
            check("t2_load_held", 32'(load_bits), 32'(rom_row(4'(i + 1))));
        end
        step();
        check("t2_done_busy", 32'(busy), 32'd0);

        // Single request raised outside the window
        goto_h(100);
        req = 4'b0001;
        req_addr = 16'h0003;
        goto_h(255);
        check("t1_no_grant_255", 32'(grant), 32'd0);
        check("t1_not_busy", 32'(busy), 32'd0);
        goto_h(256);
        check("t1_no_grant_256", 32'(grant), 32'd0);
        step();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_rom_addr", 32'(rom_addr), 32'd3);
        check("t1_busy", 32'(busy), 32'd1);
        req_addr = 16'h0005;
        step();
        check("t1_dv", 32'(data_valid), 32'b0001);
        check("t1_load_bits", 32'(load_bits), 32'hFC);
        check("t1_addr_captured", 32'(rom_addr), 32'd3);
        check("t1_grant_off", 32'(grant), 32'd0);
        req = 4'b0000;
        step();
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_dv_off", 32'(data_valid), 32'd0);

        // Withdrawal during the grant cycle still yields one strobe
        req = 4'b0100;
        req_addr = 16'h0A00;
        step();
        check("t5_grant", 32'(grant), 32'b0100);
        check("t5_rom_addr", 32'(rom_addr), 32'd10);
        req = 4'b0000;
        step();
        check("t5_dv", 32'(data_valid), 32'b0100);
        check("t5_load_bits", 32'(load_bits), 32'h6E);
        step();
        check("t5_idle", 32'(busy), 32'd0);
        step();
        check("t5_no_refetch_grant", 32'(grant), 32'd0);
        check("t5_no_refetch_busy", 32'(busy), 32'd0);

        // Round-robin: after requester 1, requester 3 beats requester 0
        req = 4'b0010;
        req_addr = 16'h0070;
        step();
        check("t3_grant1", 32'(grant), 32'b0010);
        step();
        check("t3_dv1", 32'(data_valid), 32'b0010);
        req = 4'b0000;
        step();
        req = 4'b1001;
        req_addr = 16'hC009;
        step();
        check("t3_grant3_first", 32'(grant), 32'b1000);
        check("t3_rom_addr3", 32'(rom_addr), 32'd12);
        step();
        check("t3_dv3", 32'(data_valid), 32'b1000);
        check("t3_load3", 32'(load_bits), 32'hFE);
        req = 4'b0001;
        step();
        step();
        check("t3_grant0", 32'(grant), 32'b0001);
        check("t3_rom_addr0", 32'(rom_addr), 32'd9);
        step();
        check("t3_dv0", 32'(data_valid), 32'b0001);
        check("t3_load0", 32'(load_bits), 32'h32);
        req = 4'b0000;

        // Short window (ends at 262): two served, overrun, rest next line
        goto_h(100);
        req2 = 4'b1111;
        req_addr2 = {4'd8, 4'd7, 4'd6, 4'd5};
        goto_h(256);
        step();
        check("t4_grant0", 32'(grant2), 32'b0001);
        step();
        check("t4_dv0", 32'(data_valid2), 32'b0001);
        check("t4_load0", 32'(load_bits2), 32'h60);
        req2[0] = 1'b0;
        step();
        step();
        check("t4_grant1", 32'(grant2), 32'b0010);
        step();
        check("t4_dv1", 32'(data_valid2), 32'b0010);
        check("t4_load1", 32'(load_bits2), 32'h70);
        req2[1] = 1'b0;
        step();
        check("t4_hpos262_busy", 32'(busy2), 32'd0);
        check("t4_hpos262_overrun", 32'(overrun2), 32'd0);
        step();
        check("t4_grant2_held", 32'(grant2), 32'd0);
        check("t4_overrun", 32'(overrun2), 32'd1);
        step();
        check("t4_overrun_pulse", 32'(overrun2), 32'd0);
        check("t4_still_idle", 32'(busy2), 32'd0);
        goto_h(256);
        check("t4_wait_next_line", 32'(grant2), 32'd0);
        step();
        check("t4_grant2_next", 32'(grant2), 32'b0100);
        check("t4_rom_addr2", 32'(rom_addr2), 32'd7);
        step();
        check("t4_dv2", 32'(data_valid2), 32'b0100);
        check("t4_load2", 32'(load_bits2), 32'h30);
        req2[2] = 1'b0;
        step();
        step();
        check("t4_grant3_next", 32'(grant2), 32'b1000);
        step();
        check("t4_dv3", 32'(data_valid2), 32'b1000);
        check("t4_load3", 32'(load_bits2), 32'h31);
        req2 = 4'b0000;
        goto_h(263);
        check("t4_no_overrun_line2", 32'(overrun2), 32'd0);

        // Asynchronous reset in the ADDR cycle
        goto_h(100);
        req = 4'b1111;
        req_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        goto_h(256);
        step();
        check("t6_grant_pre", 32'(grant), 32'b0010);
        check("t6_rom_addr_pre", 32'(rom_addr), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_dv", 32'(data_valid), 32'd0);
        check("t6_async_rom_addr", 32'(rom_addr), 32'd0);
        check("t6_async_load_bits", 32'(load_bits), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        step();
        check("t6_no_dv_in_reset", 32'(data_valid), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("t6_restart_grant0", 32'(grant), 32'b0001);
        check("t6_restart_rom_addr", 32'(rom_addr), 32'd1);
        step();
        check("t6_restart_dv", 32'(data_valid), 32'b0001);
        check("t6_restart_load", 32'(load_bits), 32'hCC);
        req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
